// File: rtl/cursor_control_gen.sv
// Board cursor / selection controller. Conditions five raw buttons
// (2-flop sync, debounce, press edge, hold-to-repeat), moves the cursor on a
// BOARD_W x BOARD_H board (clamp or wrap) and hands a from/to move to
// game_logic over a req/ack handshake.
//
// Auto-repeat FSM, one per direction
//   state        | meaning
//   RPT_IDLE     | debounced level low, waiting for a press
//   RPT_DELAY    | held, counting down to the first auto-repeat
//   RPT_REPEAT   | held, stepping every REPEAT_RATE cycles
//
// Selection FSM
//   state        | meaning
//   SEL_IDLE     | nothing selected
//   SEL_SELECTED | source square captured in sel_loc, sel_valid=1
//   SEL_PENDING  | move_req raised, waiting for move_ack
module cursor_control_gen #(
  parameter int BOARD_W         = 8,
  parameter int BOARD_H         = 8,
  parameter int LOC_W           = 6,
  parameter int CURSOR_INIT     = 0,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int WRAP            = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_btn_up,
  input  logic             in_btn_down,
  input  logic             in_btn_left,
  input  logic             in_btn_right,
  input  logic             in_selected,
  input  logic             move_ack,
  output logic [LOC_W-1:0] location,
  output logic [LOC_W-1:0] sel_loc,
  output logic             sel_valid,
  output logic             move_req,
  output logic [LOC_W-1:0] move_from,
  output logic [LOC_W-1:0] move_to
);

  localparam int NB      = 5;
  localparam int ND      = 4;
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_SEL   = 4;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LD = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LD  = TMR_W'(REPEAT_RATE - 1);
  localparam logic [LOC_W-1:0] COLS     = LOC_W'(BOARD_W);
  localparam logic [LOC_W-1:0] LAST_COL = LOC_W'(BOARD_W - 1);
  localparam logic [LOC_W-1:0] LAST_ROW = LOC_W'(BOARD_H - 1);
  localparam logic [LOC_W-1:0] ROW_SPAN = LOC_W'((BOARD_H - 1) * BOARD_W);
  localparam logic [LOC_W-1:0] LOC_INIT = LOC_W'(CURSOR_INIT);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;
  typedef enum logic [1:0] {SEL_IDLE, SEL_SELECTED, SEL_PENDING} sel_state_e;

  logic [NB-1:0]    btn_raw, press;
  logic [NB-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]    db_q, db_d, db_prev_q, db_prev_d;
  logic [DB_W-1:0]  db_cnt_q [NB];
  logic [DB_W-1:0]  db_cnt_d [NB];
  rpt_state_e       rpt_state_q [ND];
  rpt_state_e       rpt_state_d [ND];
  logic [TMR_W-1:0] rpt_tmr_q [ND];
  logic [TMR_W-1:0] rpt_tmr_d [ND];
  logic [ND-1:0]    step;
  logic [LOC_W-1:0] loc_q, loc_d, row, col;
  sel_state_e       sel_state_q, sel_state_d;
  logic [LOC_W-1:0] sel_loc_q, sel_loc_d, move_from_q, move_from_d, move_to_q, move_to_d;
  logic             sel_valid_q, sel_valid_d, move_req_q, move_req_d;

  assign btn_raw = {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up};

  // Sync + debounce: level flips only after DEBOUNCE_CYCLES straight mismatches.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  // Per-direction hold-to-repeat; timers count down to a terminal count of zero.
  always_comb begin
    for (int i = 0; i < ND; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_tmr_d[i]   = rpt_tmr_q[i];
      step[i]        = 1'b0;
      case (rpt_state_q[i])
        RPT_IDLE: begin
          if (press[i]) begin
            step[i]        = 1'b1;
            rpt_state_d[i] = RPT_DELAY;
            rpt_tmr_d[i]   = DELAY_LD;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (!db_q[i]) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_tmr_d[i]   = '0;
          end else if (rpt_tmr_q[i] == '0) begin
            step[i]        = 1'b1;
            rpt_state_d[i] = RPT_REPEAT;
            rpt_tmr_d[i]   = RATE_LD;
          end else begin
            rpt_tmr_d[i] = rpt_tmr_q[i] - TMR_W'(1);
          end
        end
        default: begin
          rpt_state_d[i] = RPT_IDLE;
          rpt_tmr_d[i]   = '0;
        end
      endcase
    end
  end

  // Cursor move; the if-chain order is the up > down > left > right priority.
  always_comb begin
    row   = loc_q / COLS;
    col   = loc_q % COLS;
    loc_d = loc_q;
    if (step[B_UP]) begin
      if (row != '0)                loc_d = loc_q - COLS;
      else if (WRAP != 0)           loc_d = loc_q + ROW_SPAN;
    end else if (step[B_DOWN]) begin
      if (row != LAST_ROW)          loc_d = loc_q + COLS;
      else if (WRAP != 0)           loc_d = col;
    end else if (step[B_LEFT]) begin
      if (col != '0)                loc_d = loc_q - LOC_W'(1);
      else if (WRAP != 0)           loc_d = loc_q + LAST_COL;
    end else if (step[B_RIGHT]) begin
      if (col != LAST_COL)          loc_d = loc_q + LOC_W'(1);
      else if (WRAP != 0)           loc_d = loc_q - LAST_COL;
    end
  end

  // Selection / move handshake; uses the pre-step cursor location.
  always_comb begin
    sel_state_d = sel_state_q;
    sel_loc_d   = sel_loc_q;
    sel_valid_d = sel_valid_q;
    move_req_d  = move_req_q;
    move_from_d = move_from_q;
    move_to_d   = move_to_q;
    case (sel_state_q)
      SEL_IDLE: begin
        if (press[B_SEL]) begin
          sel_loc_d   = loc_q;
          sel_valid_d = 1'b1;
          sel_state_d = SEL_SELECTED;
        end
      end
      SEL_SELECTED: begin
        if (press[B_SEL]) begin
          if (loc_q == sel_loc_q) begin
            sel_valid_d = 1'b0;
            sel_state_d = SEL_IDLE;
          end else begin
            move_from_d = sel_loc_q;
            move_to_d   = loc_q;
            move_req_d  = 1'b1;
            sel_state_d = SEL_PENDING;
          end
        end
      end
      SEL_PENDING: begin
        if (move_ack) begin
          move_req_d  = 1'b0;
          sel_valid_d = 1'b0;
          sel_state_d = SEL_IDLE;
        end
      end
      default: sel_state_d = SEL_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < ND; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
        rpt_tmr_q[i]   <= '0;
      end
      loc_q       <= LOC_INIT;
      sel_state_q <= SEL_IDLE;
      sel_loc_q   <= '0;
      sel_valid_q <= 1'b0;
      move_req_q  <= 1'b0;
      move_from_q <= '0;
      move_to_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_prev_q   <= db_prev_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < ND; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_tmr_q[i]   <= rpt_tmr_d[i];
      end
      loc_q       <= loc_d;
      sel_state_q <= sel_state_d;
      sel_loc_q   <= sel_loc_d;
      sel_valid_q <= sel_valid_d;
      move_req_q  <= move_req_d;
      move_from_q <= move_from_d;
      move_to_q   <= move_to_d;
    end
  end

  assign location  = loc_q;
  assign sel_loc   = sel_loc_q;
  assign sel_valid = sel_valid_q;
  assign move_req  = move_req_q;
  assign move_from = move_from_q;
  assign move_to   = move_to_q;

endmodule

// File: tb/tb_cursor_control_gen.sv
// Bench for cursor_control_gen: a clamp (WRAP=0) and a wrap (WRAP=1) instance
// share all stimulus. Expected output values are pushed with the cycle they
// are due when a button is driven, and compared when that cycle arrives.
module tb_cursor_control_gen;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_sel = 1'b0, ack = 1'b0;

  logic [LW-1:0] loc_c, sel_loc_c, from_c, to_c;
  logic          selv_c, mreq_c;
  logic [LW-1:0] loc_w, sel_loc_w, from_w, to_w;
  logic          selv_w, mreq_w;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cursor_control_gen #(.BOARD_W(W), .BOARD_H(H), .LOC_W(LW), .CURSOR_INIT(0),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(0)) dut_clamp (
    .clk(clk), .rst(rst), .in_btn_up(b_up), .in_btn_down(b_down), .in_btn_left(b_left),
    .in_btn_right(b_right), .in_selected(b_sel), .move_ack(ack),
    .location(loc_c), .sel_loc(sel_loc_c), .sel_valid(selv_c), .move_req(mreq_c),
    .move_from(from_c), .move_to(to_c));

  cursor_control_gen #(.BOARD_W(W), .BOARD_H(H), .LOC_W(LW), .CURSOR_INIT(0),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .in_btn_up(b_up), .in_btn_down(b_down), .in_btn_left(b_left),
    .in_btn_right(b_right), .in_selected(b_sel), .move_ack(ack),
    .location(loc_w), .sel_loc(sel_loc_w), .sel_valid(selv_w), .move_req(mreq_w),
    .move_from(from_w), .move_to(to_w));

  // observation index: 0..5 clamp instance, 6..11 wrap instance
  localparam int O_LOC = 0, O_SELV = 1, O_SLOC = 2, O_MREQ = 3, O_FROM = 4, O_TO = 5, O_W = 6;
  string names [12] = '{"loc_c", "selv_c", "sel_loc_c", "mreq_c", "from_c", "to_c",
                        "loc_w", "selv_w", "sel_loc_w", "mreq_w", "from_w", "to_w"};

  typedef struct { int sel; int due; int exp; } sb_t;
  sb_t sb_q[$];

  // model state
  int m_loc_c, m_loc_w;
  int m_state, m_sel_loc, m_selv, m_req, m_from, m_to;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_obs(input int sel);
    case (sel)
      0:  return 32'(loc_c);
      1:  return 32'(selv_c);
      2:  return 32'(sel_loc_c);
      3:  return 32'(mreq_c);
      4:  return 32'(from_c);
      5:  return 32'(to_c);
      6:  return 32'(loc_w);
      7:  return 32'(selv_w);
      8:  return 32'(sel_loc_w);
      9:  return 32'(mreq_w);
      10: return 32'(from_w);
      default: return 32'(to_w);
    endcase
  endfunction

  function automatic int next_loc(input int loc, input int dir, input int wrap);
    int r;
    int c;
    r = loc / W;
    c = loc % W;
    case (dir)
      0: if (r > 0) r--; else if (wrap != 0) r = H - 1;
      1: if (r < H - 1) r++; else if (wrap != 0) r = 0;
      2: if (c > 0) c--; else if (wrap != 0) c = W - 1;
      default: if (c < W - 1) c++; else if (wrap != 0) c = 0;
    endcase
    return r * W + c;
  endfunction

  task automatic push(input int sel, input int due, input int exp);
    sb_t e;
    e.sel = sel; e.due = due; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_sel_all(input int due);
    for (int k = 0; k <= O_W; k += O_W) begin
      push(k + O_SELV, due, m_selv);
      push(k + O_SLOC, due, m_sel_loc);
      push(k + O_MREQ, due, m_req);
      push(k + O_FROM, due, m_from);
      push(k + O_TO,   due, m_to);
    end
  endtask

  // compare every entry due this cycle
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_val(names[sb_q[i].sel], get_obs(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic do_reset();
    int j;
    @(negedge clk);
    rst = 1'b1;
    j = cyc;
    m_loc_c = 0; m_loc_w = 0;
    m_state = 0; m_sel_loc = 0; m_selv = 0; m_req = 0; m_from = 0; m_to = 0;
    push(O_LOC, j + 2, 0);
    push(O_W + O_LOC, j + 2, 0);
    push_sel_all(j + 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // mask bits: [0] up, [1] down, [2] left, [3] right
  task automatic press_dirs(input logic [3:0] mask);
    int n;
    int d;
    @(negedge clk);
    n = cyc;
    {b_right, b_left, b_down, b_up} = mask;
    d = 3;
    for (int k = 3; k >= 0; k--) if (mask[k]) d = k;
    push(O_LOC, n + 6, m_loc_c);
    push(O_W + O_LOC, n + 6, m_loc_w);
    m_loc_c = next_loc(m_loc_c, d, 0);
    m_loc_w = next_loc(m_loc_w, d, 1);
    push(O_LOC, n + 7, m_loc_c);
    push(O_W + O_LOC, n + 7, m_loc_w);
    repeat (8) @(negedge clk);
    {b_right, b_left, b_down, b_up} = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_sel();
    int n;
    @(negedge clk);
    n = cyc;
    b_sel = 1'b1;
    push(O_SELV, n + 6, m_selv);
    case (m_state)
      0: begin m_sel_loc = m_loc_c; m_selv = 1; m_state = 1; end
      1: begin
        if (m_loc_c == m_sel_loc) begin m_selv = 0; m_state = 0; end
        else begin m_from = m_sel_loc; m_to = m_loc_c; m_req = 1; m_state = 2; end
      end
      default: ;
    endcase
    push_sel_all(n + 7);
    repeat (8) @(negedge clk);
    b_sel = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_ack();
    int n;
    @(negedge clk);
    n = cyc;
    ack = 1'b1;
    if (m_state == 2) begin m_req = 0; m_selv = 0; m_state = 0; end
    push_sel_all(n + 1);
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    do_reset();
    repeat (5) @(negedge clk);

    // bounce on right: only the final stable rise is accepted
    for (int i = 0; i < 20; i++) begin
      b_right = ((i % 4) < 2);
      @(negedge clk);
    end
    n = cyc;
    b_right = 1'b1;
    push(O_LOC, n + 6, 0);
    push(O_LOC, n + 7, 1);
    push(O_LOC, n + 30, 1);
    push(O_W + O_LOC, n + 7, 1);
    m_loc_c = 1; m_loc_w = 1;
    repeat (8) @(negedge clk);
    b_right = 1'b0;
    repeat (25) @(negedge clk);

    // walk to column 7, then hit the right and top edges
    repeat (6) press_dirs(4'b1000);
    press_dirs(4'b1000);   // clamp stays 7, wrap goes to 0
    press_dirs(4'b0001);   // clamp stays 7 (row 0), wrap 0 -> 56

    do_reset();
    repeat (5) @(negedge clk);

    // auto-repeat on down from 0
    @(negedge clk);
    n = cyc;
    b_down = 1'b1;
    for (int i = 0; i <= O_W; i += O_W) begin
      push(i + O_LOC, n + 6, 0);
      push(i + O_LOC, n + 7, 8);
      push(i + O_LOC, n + 26, 8);
      push(i + O_LOC, n + 27, 16);
      push(i + O_LOC, n + 32, 24);
      push(i + O_LOC, n + 37, 32);
      push(i + O_LOC, n + 42, 40);
      push(i + O_LOC, n + 60, 40);
    end
    m_loc_c = 40; m_loc_w = 40;
    repeat (38) @(negedge clk);
    b_down = 1'b0;
    repeat (35) @(negedge clk);

    // to 27, then up+left together: only up is taken
    press_dirs(4'b0001);
    press_dirs(4'b0001);
    repeat (3) press_dirs(4'b1000);
    press_dirs(4'b0101);
    push(O_LOC, cyc + 5, 19);

    // select at 9, move to 18, select again -> move request
    press_dirs(4'b0001);
    press_dirs(4'b0100);
    press_dirs(4'b0100);
    press_sel();
    press_dirs(4'b0010);
    press_dirs(4'b1000);
    press_sel();
    press_sel();           // ignored while pending
    press_dirs(4'b1000);   // cursor still moves; from/to held
    push_sel_all(cyc + 2);
    repeat (3) @(negedge clk);
    pulse_ack();

    // same square twice -> deselect; ack outside PENDING is ignored
    press_sel();
    pulse_ack();
    press_sel();

    // pending again, then reset while up is held
    press_sel();
    press_dirs(4'b0100);
    press_sel();
    @(negedge clk);
    b_up = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    k = cyc;
    push(O_W + O_LOC, k + 6, 0);
    push(O_W + O_LOC, k + 7, 56);
    push(O_LOC, k + 7, 0);
    push(O_MREQ, k + 7, 0);
    repeat (8) @(negedge clk);
    b_up = 1'b0;
    m_loc_w = 56;

    repeat (30) @(negedge clk);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
